// File: rtl/vga_dac_pkg.sv
// Shared definitions for the VGA DAC palette: CSR offsets, DAC state codes,
// component-sequencing states and the palette entry layout.
package vga_dac_pkg;

    localparam int unsigned COMP_W_DEF = 6;
    localparam int unsigned PAL_AW_DEF = 8;

    localparam logic [1:0] ADR_PEL_MASK = 2'd0;  // 3C6
    localparam logic [1:0] ADR_RD_IDX   = 2'd1;  // 3C7
    localparam logic [1:0] ADR_WR_IDX   = 2'd2;  // 3C8
    localparam logic [1:0] ADR_DATA     = 2'd3;  // 3C9

    localparam logic [1:0] DAC_ST_WRITE = 2'b00;
    localparam logic [1:0] DAC_ST_READ  = 2'b11;

    typedef enum logic [1:0] {
        S_R = 2'd0,
        S_G = 2'd1,
        S_B = 2'd2
    } sub_t;

    typedef struct packed {
        logic [COMP_W_DEF-1:0] r;
        logic [COMP_W_DEF-1:0] g;
        logic [COMP_W_DEF-1:0] b;
    } pal_entry_t;

endpackage

// File: rtl/vga_dac_ram.sv
// True dual-port synchronous palette RAM. Port A read-only (pixel path),
// port B read/write (CPU), both read-before-write.
module vga_dac_ram
    import vga_dac_pkg::*;
#(
    parameter int unsigned AW = PAL_AW_DEF,
    parameter int unsigned DW = 3 * COMP_W_DEF
) (
    input  logic          clk,
    input  logic          en_a,
    input  logic [AW-1:0] addr_a,
    output logic [DW-1:0] q_a,
    input  logic          en_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] d_b,
    output logic [DW-1:0] q_b
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Reads sample the array before the same-edge write lands.
    always_ff @(posedge clk) begin
        if (en_a) begin
            q_a <= mem[addr_a];
        end
        if (en_b) begin
            q_b <= mem[addr_b];
            if (we_b) begin
                mem[addr_b] <= d_b;
            end
        end
    end

endmodule

// File: rtl/vga_dac_palette.sv
// VGA DAC: PEL-masked palette lookup with blank gating and sync delay,
// plus the 3C6..3C9 register set on a byte-wide CSR slave.
module vga_dac_palette
    import vga_dac_pkg::*;
#(
    parameter int unsigned COMP_W = COMP_W_DEF,
    parameter int unsigned PAL_AW = PAL_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        color,
    input  logic              video_on_h_i,
    input  logic              horiz_sync_i,
    input  logic [1:0]        csr_adr_i,
    input  logic              csr_we_i,
    input  logic              csr_stb_i,
    input  logic [7:0]        csr_dat_i,
    output logic [7:0]        csr_dat_o,
    output logic              csr_ack_o,
    output logic [COMP_W-1:0] red,
    output logic [COMP_W-1:0] green,
    output logic [COMP_W-1:0] blue,
    output logic              video_on_h_o,
    output logic              horiz_sync_o
);

    localparam int unsigned PAL_DW = 3 * COMP_W;

    logic [7:0]        pel_mask;
    logic [PAL_AW-1:0] rd_idx;
    logic [PAL_AW-1:0] wr_idx;
    logic [1:0]        dac_state;
    logic [COMP_W-1:0] tmp_r;
    logic [COMP_W-1:0] tmp_g;
    logic              rd_pend;
    sub_t              wr_sub, wr_sub_nxt;
    sub_t              rd_sub, rd_sub_nxt;
    logic              vo_s1, hs_s1;
    logic [PAL_DW-1:0] pix_q;
    logic [PAL_DW-1:0] cpu_q;

    logic              acc_c, wr_acc_c, rd_acc_c;
    logic              data_wr_c, data_rd_start_c, pal_we_c;
    logic [PAL_AW-1:0] ram_b_addr_c;
    logic [7:0]        rd_dat_c;

    // A new access is taken only when idle: not acking and no data read in flight.
    always_comb begin
        acc_c           = csr_stb_i & ~csr_ack_o & ~rd_pend;
        wr_acc_c        = acc_c & csr_we_i;
        rd_acc_c        = acc_c & ~csr_we_i;
        data_wr_c       = wr_acc_c & (csr_adr_i == ADR_DATA);
        data_rd_start_c = rd_acc_c & (csr_adr_i == ADR_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sub <= S_R;
            rd_sub <= S_R;
        end else begin
            wr_sub <= wr_sub_nxt;
            rd_sub <= rd_sub_nxt;
        end
    end

    // Component sequencing; index writes restart the triplet of their direction.
    always_comb begin
        wr_sub_nxt = wr_sub;
        rd_sub_nxt = rd_sub;
        if (wr_acc_c && csr_adr_i == ADR_WR_IDX) begin
            wr_sub_nxt = S_R;
        end else if (data_wr_c) begin
            case (wr_sub)
                S_R:     wr_sub_nxt = S_G;
                S_G:     wr_sub_nxt = S_B;
                default: wr_sub_nxt = S_R;
            endcase
        end
        if (wr_acc_c && csr_adr_i == ADR_RD_IDX) begin
            rd_sub_nxt = S_R;
        end else if (rd_pend) begin
            case (rd_sub)
                S_R:     rd_sub_nxt = S_G;
                S_G:     rd_sub_nxt = S_B;
                default: rd_sub_nxt = S_R;
            endcase
        end
    end

    always_comb begin
        pal_we_c     = data_wr_c & (wr_sub == S_B);
        ram_b_addr_c = pal_we_c ? wr_idx : rd_idx;
        rd_dat_c     = 8'h00;
        if (rd_pend) begin
            case (rd_sub)
                S_R:     rd_dat_c = 8'(cpu_q[PAL_DW-1 -: COMP_W]);
                S_G:     rd_dat_c = 8'(cpu_q[2*COMP_W-1 -: COMP_W]);
                default: rd_dat_c = 8'(cpu_q[COMP_W-1:0]);
            endcase
        end else begin
            case (csr_adr_i)
                ADR_PEL_MASK: rd_dat_c = pel_mask;
                ADR_RD_IDX:   rd_dat_c = {6'b0, dac_state};
                ADR_WR_IDX:   rd_dat_c = 8'(wr_idx);
                default:      rd_dat_c = 8'h00;
            endcase
        end
    end

    // CSR registers, ack and read-data; data reads ack one clock later than the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            pel_mask  <= 8'hFF;
            rd_idx    <= '0;
            wr_idx    <= '0;
            dac_state <= DAC_ST_WRITE;
            tmp_r     <= '0;
            tmp_g     <= '0;
            rd_pend   <= 1'b0;
            csr_ack_o <= 1'b0;
            csr_dat_o <= 8'h00;
        end else begin
            rd_pend   <= data_rd_start_c;
            csr_ack_o <= (acc_c & ~data_rd_start_c) | rd_pend;
            csr_dat_o <= ((rd_acc_c & ~data_rd_start_c) | rd_pend) ? rd_dat_c : 8'h00;
            if (wr_acc_c) begin
                case (csr_adr_i)
                    ADR_PEL_MASK: pel_mask <= csr_dat_i;
                    ADR_RD_IDX: begin
                        rd_idx    <= PAL_AW'(csr_dat_i);
                        dac_state <= DAC_ST_READ;
                    end
                    ADR_WR_IDX: begin
                        wr_idx    <= PAL_AW'(csr_dat_i);
                        dac_state <= DAC_ST_WRITE;
                    end
                    default: begin
                        case (wr_sub)
                            S_R:     tmp_r  <= csr_dat_i[COMP_W-1:0];
                            S_G:     tmp_g  <= csr_dat_i[COMP_W-1:0];
                            default: wr_idx <= wr_idx + PAL_AW'(1);
                        endcase
                    end
                endcase
            end
            if (rd_pend && rd_sub == S_B) begin
                rd_idx <= rd_idx + PAL_AW'(1);
            end
        end
    end

    vga_dac_ram #(
        .AW (PAL_AW),
        .DW (PAL_DW)
    ) u_ram (
        .clk    (clk),
        .en_a   (enable),
        .addr_a (PAL_AW'(color & pel_mask)),
        .q_a    (pix_q),
        .en_b   (data_rd_start_c | pal_we_c),
        .we_b   (pal_we_c),
        .addr_b (ram_b_addr_c),
        .d_b    ({tmp_r, tmp_g, csr_dat_i[COMP_W-1:0]}),
        .q_b    (cpu_q)
    );

    // Pixel pipeline: stage 1 is the RAM lookup, stage 2 the blank-gated output.
    always_ff @(posedge clk) begin
        if (rst) begin
            vo_s1        <= 1'b0;
            hs_s1        <= 1'b0;
            video_on_h_o <= 1'b0;
            horiz_sync_o <= 1'b0;
            red          <= '0;
            green        <= '0;
            blue         <= '0;
        end else if (enable) begin
            vo_s1        <= video_on_h_i;
            hs_s1        <= horiz_sync_i;
            video_on_h_o <= vo_s1;
            horiz_sync_o <= hs_s1;
            {red, green, blue} <= vo_s1 ? pix_q : '0;
        end
    end

endmodule
